// File: rtl/float_to_fixed_seq_pkg.sv
// Shared constants and FSM encoding for the float -> sign-magnitude fixed-point converter.
package float_to_fixed_seq_pkg;

    localparam int FLT_BIAS   = 127;
    localparam int FLT_EXP_W  = 8;
    localparam int FLT_MAN_W  = 23;
    localparam int FLT_SIG_W  = FLT_MAN_W + 1;
    localparam int FIX_FRAC_W = 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/float_to_fixed_seq_unpack.sv
// Combinational IEEE-754 single-precision field decoder, reusable by any float-consuming stage.
module float_to_fixed_seq_unpack
    import float_to_fixed_seq_pkg::*;
(
    input  logic [31:0]          data,
    output logic                 sign,
    output logic [FLT_EXP_W-1:0] exp,
    output logic                 is_zero,
    output logic                 is_nan,
    output logic                 is_inf,
    output logic [FLT_SIG_W-1:0] sig
);

    logic [FLT_MAN_W-1:0] man;

    assign sign = data[31];
    assign exp  = data[30:23];
    assign man  = data[22:0];

    // Denormals count as zero: they are far below the smallest representable fixed-point step.
    assign is_zero = (exp == '0);
    assign is_nan  = (exp == '1) && (man != '0);
    assign is_inf  = (exp == '1) && (man == '0);
    assign sig     = {(exp != '0), man};

endmodule

// File: rtl/float_to_fixed_seq.sv
// Iterative float -> fixed converter: one right-shift per cycle, valid/ready on both sides.
module float_to_fixed_seq
    import float_to_fixed_seq_pkg::*;
#(
    parameter  int FRAC_W = FIX_FRAC_W,
    parameter  bit SAT_EN = 1'b1,
    localparam int FIX_W  = FRAC_W + 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FIX_W-1:0] out_data,
    output logic             out_ovf,
    output logic             out_inv,
    output logic [1:0]       dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // in_ready is high only in IDLE; out_valid is high only in DONE and its payload is held
    // unchanged until the consumer takes it.

    state_t               state;
    logic                 sign_q;
    logic [FLT_SIG_W-1:0] shifter;
    logic [4:0]           count;

    logic                 u_sign;
    logic [FLT_EXP_W-1:0] u_exp;
    logic                 u_zero;
    logic                 u_nan;
    logic                 u_inf;
    logic [FLT_SIG_W-1:0] u_sig;
    logic signed [8:0]    sh;
    logic                 accept;

    float_to_fixed_seq_unpack u_unpack (
        .data    (in_data),
        .sign    (u_sign),
        .exp     (u_exp),
        .is_zero (u_zero),
        .is_nan  (u_nan),
        .is_inf  (u_inf),
        .sig     (u_sig)
    );

    // Right-shift needed to align the 24-bit significand onto the FRAC_W-bit fraction grid.
    assign sh        = 9'(150 - FRAC_W) - 9'(u_exp);
    assign accept    = in_valid && in_ready;
    assign dbg_state = state;

    // Magnitude-zero results never carry a sign, so -0 cannot appear on the output.
    function automatic logic [FIX_W-1:0] pack(input logic s, input logic [FLT_SIG_W-1:0] v);
        logic [FRAC_W:0] mag;
        mag = v[FRAC_W:0];
        return {s & (|mag), mag};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_inv   <= 1'b0;
            sign_q    <= 1'b0;
            shifter   <= '0;
            count     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        out_ovf  <= 1'b0;
                        out_inv  <= 1'b0;
                        sign_q   <= u_sign;
                        if (u_nan) begin
                            out_data  <= '0;
                            out_inv   <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else if (u_inf || u_exp[FLT_EXP_W-1]) begin
                            out_ovf   <= 1'b1;
                            out_data  <= SAT_EN ? {u_sign, {(FRAC_W+1){1'b1}}} : '0;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else if (u_zero || (sh >= 9'sd24)) begin
                            out_data  <= '0;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else if (sh == 9'sd0) begin
                            // Only reachable with FRAC_W=23: significand is already aligned.
                            out_data  <= pack(u_sign, u_sig);
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            shifter <= u_sig;
                            count   <= sh[4:0];
                            state   <= ST_SHIFT;
                        end
                    end
                end

                ST_SHIFT: begin
                    shifter <= shifter >> 1;
                    count   <= count - 5'd1;
                    if (count == 5'd1) begin
                        out_data  <= pack(sign_q, shifter >> 1);
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
